// File: rtl/ffo_pkg.sv
// Shared types and width helpers for the sequential find-first-one scanner.
package ffo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        ZERO = 2'd2
    } state_t;

    // Width of a bit position inside an n-bit vector.
    function automatic int unsigned pos_w(input int unsigned n);
        return $clog2(n);
    endfunction

    // Width of a beat counter able to hold 0..n.
    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ffo_tree.sv
// Recursive combinational first-one tree; index 0 of vec has highest priority.
module ffo_tree
    import ffo_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic [0:N-1]          vec,
    output logic                  v,
    output logic [pos_w(N)-1:0]   p
);

    generate
        if (N == 2) begin : g_leaf
            // Two-input leaf: prefer bit 0 when both are set.
            assign v = vec[0] | vec[1];
            assign p = ~vec[0];
        end else begin : g_merge
            localparam int unsigned H  = N / 2;
            localparam int unsigned HW = pos_w(H);

            logic          vl;
            logic          vr;
            logic [HW-1:0] pl;
            logic [HW-1:0] pr;

            ffo_tree #(.N(H)) u_lo_idx (.vec(vec[0:H-1]), .v(vl), .p(pl));
            ffo_tree #(.N(H)) u_hi_idx (.vec(vec[H:N-1]), .v(vr), .p(pr));

            // Merge: the lower-index half wins whenever it has any set bit.
            assign v = vl | vr;
            assign p = vl ? {1'b0, pl} : {1'b1, pr};
        end
    endgenerate

endmodule

// File: rtl/ffo_scan.sv
// Sequential find-first-one scanner: emits one set-bit position per beat.
// Optional macro FFO_SCAN_DIR_EN adds in_dir (1 = scan from index N-1 down).
module ffo_scan
    import ffo_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [0:N-1]          in_vec,
    input  logic                  in_valid,
`ifdef FFO_SCAN_DIR_EN
    input  logic                  in_dir,
`endif
    output logic                  in_ready,
    output logic [pos_w(N)-1:0]   out_pos,
    output logic [cnt_w(N)-1:0]   out_cnt,
    output logic                  out_last,
    output logic                  out_none,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int unsigned PW = pos_w(N);
    localparam int unsigned CW = cnt_w(N);

    state_t        state;
    logic [0:N-1]  work;
    logic [0:N-1]  work_clr;
    logic [0:N-1]  tree_in;
    logic [CW-1:0] cnt;
    logic          tree_v;
    logic [PW-1:0] tree_p;
    logic [PW-1:0] first_pos;
    logic          accept;
    logic          fire;

`ifdef FFO_SCAN_DIR_EN
    logic          dir_q;

    // Reverse the working vector for last-first scans and map back to absolute index.
    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            tree_in[i] = dir_q ? work[N-1-i] : work[i];
        end
        first_pos = dir_q ? (PW'(N - 1) - tree_p) : tree_p;
    end
`else
    // Index-0-first scan only.
    always_comb begin
        tree_in   = work;
        first_pos = tree_p;
    end
`endif

    ffo_tree #(.N(N)) u_tree (.vec(tree_in), .v(tree_v), .p(tree_p));

    // Working vector with the currently reported bit removed.
    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            work_clr[i] = work[i] & (first_pos != PW'(i));
        end
    end

    // Output beat decode from the state/work/cnt registers only.
    always_comb begin
        out_valid = 1'b0;
        out_pos   = '0;
        out_cnt   = '0;
        out_last  = 1'b0;
        out_none  = 1'b0;
        unique case (state)
            SCAN: begin
                out_valid = tree_v;
                out_pos   = first_pos;
                out_cnt   = cnt;
                out_last  = ~|work_clr;
            end
            ZERO: begin
                out_valid = 1'b1;
                out_none  = 1'b1;
                out_last  = 1'b1;
            end
            default: begin
                out_valid = 1'b0;
            end
        endcase
    end

    // Ready in IDLE, or on the final accepted beat to chain the next vector bubble-free.
    always_comb begin
        in_ready = (state == IDLE) | (out_valid & out_ready & out_last);
        accept   = in_valid & in_ready;
        fire     = out_valid & out_ready;
    end

    // State, working vector and beat counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            work  <= '0;
            cnt   <= '0;
`ifdef FFO_SCAN_DIR_EN
            dir_q <= 1'b0;
`endif
        end else if (accept) begin
            work  <= in_vec;
            cnt   <= '0;
`ifdef FFO_SCAN_DIR_EN
            dir_q <= in_dir;
`endif
            state <= (|in_vec) ? SCAN : ZERO;
        end else if (fire) begin
            if (state == SCAN) begin
                work <= work_clr;
                cnt  <= cnt + CW'(1);
                if (out_last) begin
                    state <= IDLE;
                end
            end else begin
                state <= IDLE;
            end
        end
    end

endmodule
